// File: rtl/resonance_tracker_pkg.sv
// Shared constants and state encoding for the cutting-horn resonance tracker.
// Defaults are reused by the phase estimator and the drive waveform generator.
package resonance_tracker_pkg;

   localparam int PER_W        = 8;
   localparam int TH_W         = 8;
   localparam int DEF_PER_MIN  = 140;
   localparam int DEF_PER_MAX  = 175;
   localparam int DEF_SETTLE   = 4;
   localparam int DEF_LOCK_TOL = 8;
   localparam int DEF_LOSS_CNT = 16;

   localparam logic [TH_W-1:0] THETA_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_TRACK = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

endpackage

// File: rtl/resonance_tracker_if.sv
// Phase-estimator to tracker to drive-generator bundle; master is the estimator/controller side.
// Strobe-based, no backpressure: theta_valid is a one-cycle pulse per drive cycle.
interface resonance_tracker_if;
   import resonance_tracker_pkg::*;

   logic             enable;
   logic             theta_valid;
   logic [TH_W-1:0]  abs_theta;
   logic [PER_W-1:0] period;
   logic [TH_W-1:0]  best_theta;
   logic             sweep_busy;
   logic             locked;
   logic             fault;

   modport master (
      output enable, theta_valid, abs_theta,
      input  period, best_theta, sweep_busy, locked, fault
   );

   modport slave (
      input  enable, theta_valid, abs_theta,
      output period, best_theta, sweep_busy, locked, fault
   );

endinterface

// File: rtl/resonance_tracker_settle_gate.sv
// Counts theta_valid strobes after a period change; eval fires combinationally on the SETTLE-th.
// No backpressure; counter saturates at SETTLE and clears on clr or on its own eval.
module settle_gate #(
   parameter int SETTLE = 4
) (
   input  logic clk5MHz,
   input  logic rst_n,
   input  logic theta_valid,
   input  logic clr,
   output logic eval
);

   localparam int CW = $clog2(SETTLE + 1);

   logic [CW-1:0] cnt_q;

   assign eval = theta_valid && (cnt_q == CW'(SETTLE - 1));

   // Clearing on eval also restarts settling when a clamp leaves the period unchanged.
   always_ff @(posedge clk5MHz) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || eval) begin
         cnt_q <= '0;
      end else if (theta_valid && (cnt_q != CW'(SETTLE))) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/resonance_tracker.sv
// Sweeps the drive period for minimum |theta|, locks, then hill-climbs to follow drift.
// Period update lands one clock after the eval strobe; no backpressure on theta_valid.
module resonance_tracker
   import resonance_tracker_pkg::*;
#(
   parameter int PER_MIN  = DEF_PER_MIN,
   parameter int PER_MAX  = DEF_PER_MAX,
   parameter int SETTLE   = DEF_SETTLE,
   parameter int LOCK_TOL = DEF_LOCK_TOL,
   parameter int LOSS_CNT = DEF_LOSS_CNT
) (
   input logic                clk5MHz,
   input logic                rst_n,
   resonance_tracker_if.slave trk
);

   localparam int LW = $clog2(LOSS_CNT + 1);
   localparam logic [PER_W-1:0] P_MIN = PER_W'(PER_MIN);
   localparam logic [PER_W-1:0] P_MAX = PER_W'(PER_MAX);
   localparam logic [TH_W-1:0]  TOL   = TH_W'(LOCK_TOL);

   state_t           state_q, state_d;
   logic [PER_W-1:0] period_q, period_d;
   logic [PER_W-1:0] best_per_q, best_per_d;
   logic [TH_W-1:0]  best_q, best_d;
   logic [TH_W-1:0]  prev_q, prev_d;
   logic             dir_up_q, dir_up_d;
   logic [LW-1:0]    loss_q, loss_d;
   logic             locked_q, locked_d;

   logic             run;
   logic             eval;
   logic             new_best;
   logic [TH_W-1:0]  cand_theta;
   logic [PER_W-1:0] cand_per;
   logic             in_tol;
   logic             step_up;

   assign run = (state_q == ST_SWEEP) || (state_q == ST_TRACK);

   settle_gate #(.SETTLE(SETTLE)) u_gate (
      .clk5MHz     (clk5MHz),
      .rst_n       (rst_n),
      .theta_valid (trk.theta_valid && run),
      .clr         (!run || !trk.enable),
      .eval        (eval)
   );

   // Strict compare: on a tie the earlier (longer) period stays best.
   assign new_best   = trk.abs_theta < best_q;
   assign cand_theta = new_best ? trk.abs_theta : best_q;
   assign cand_per   = new_best ? period_q : best_per_q;
   assign in_tol     = trk.abs_theta <= TOL;
   assign step_up    = (trk.abs_theta > prev_q) ? !dir_up_q : dir_up_q;

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      best_d     = best_q;
      best_per_d = best_per_q;
      prev_d     = prev_q;
      dir_up_d   = dir_up_q;
      loss_d     = loss_q;
      locked_d   = locked_q;

      if (!trk.enable) begin
         state_d    = ST_IDLE;
         period_d   = P_MAX;
         best_per_d = P_MAX;
         dir_up_d   = 1'b0;
         loss_d     = '0;
         locked_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d    = ST_SWEEP;
               period_d   = P_MAX;
               best_d     = THETA_MAX;
               best_per_d = P_MAX;
               loss_d     = '0;
            end
            ST_SWEEP: begin
               if (eval) begin
                  best_d     = cand_theta;
                  best_per_d = cand_per;
                  if (period_q == P_MIN) begin
                     if (cand_theta <= TOL) begin
                        state_d  = ST_TRACK;
                        period_d = cand_per;
                        prev_d   = cand_theta;
                        loss_d   = '0;
                     end else begin
                        state_d  = ST_FAULT;
                        period_d = P_MAX;
                     end
                  end else begin
                     period_d = period_q - PER_W'(1);
                  end
               end
            end
            ST_TRACK: begin
               if (eval) begin
                  locked_d = in_tol;
                  prev_d   = trk.abs_theta;
                  loss_d   = in_tol ? '0 : loss_q + LW'(1);
                  if (!in_tol && (loss_q == LW'(LOSS_CNT - 1))) begin
                     state_d    = ST_SWEEP;
                     period_d   = P_MAX;
                     locked_d   = 1'b0;
                     best_d     = THETA_MAX;
                     best_per_d = P_MAX;
                     loss_d     = '0;
                  end else if (step_up && (period_q == P_MAX)) begin
                     dir_up_d = 1'b0;
                  end else if (!step_up && (period_q == P_MIN)) begin
                     dir_up_d = 1'b1;
                  end else begin
                     dir_up_d = step_up;
                     period_d = step_up ? period_q + PER_W'(1) : period_q - PER_W'(1);
                  end
               end
            end
            ST_FAULT: begin
               period_d = P_MAX;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk5MHz) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         period_q   <= P_MAX;
         best_q     <= THETA_MAX;
         best_per_q <= P_MAX;
         prev_q     <= '0;
         dir_up_q   <= 1'b0;
         loss_q     <= '0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         best_q     <= best_d;
         best_per_q <= best_per_d;
         prev_q     <= prev_d;
         dir_up_q   <= dir_up_d;
         loss_q     <= loss_d;
         locked_q   <= locked_d;
      end
   end

   assign trk.period     = period_q;
   assign trk.best_theta = best_q;
   assign trk.sweep_busy = (state_q == ST_SWEEP);
   assign trk.locked     = locked_q;
   assign trk.fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_resonance_tracker.sv
// Bench for resonance_tracker: directed horn scenarios plus random theta/enable/reset traffic,
// all checked against a cycle-level behavioural model of the sweep/track rules.
module tb_resonance_tracker;

   localparam int M_IDLE  = 0;
   localparam int M_SWEEP = 1;
   localparam int M_TRACK = 2;
   localparam int M_FAULT = 3;

   logic clk5MHz = 1'b0;
   logic rst_n   = 1'b0;

   resonance_tracker_if bus ();

   resonance_tracker dut (
      .clk5MHz (clk5MHz),
      .rst_n   (rst_n),
      .trk     (bus)
   );

   always #5 clk5MHz = ~clk5MHz;

   int n_chk = 0;
   int n_err = 0;

   // Behavioural model state
   int m_mode, m_per, m_best, m_best_per, m_prev, m_dir, m_cnt, m_loss, m_locked;
   int pres     = 158;
   int force_th = -1;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int theta_for(input int p);
      int d;
      if (force_th >= 0) return force_th;
      d = (p > pres) ? p - pres : pres - p;
      return (4 * d > 255) ? 255 : 4 * d;
   endfunction

   task automatic sweep_eval(input int th);
      if (th < m_best) begin
         m_best     = th;
         m_best_per = m_per;
      end
      if (m_per == 140) begin
         if (m_best <= 8) begin
            m_mode = M_TRACK;
            m_per  = m_best_per;
            m_prev = m_best;
            m_loss = 0;
         end else begin
            m_mode = M_FAULT;
            m_per  = 175;
         end
      end else begin
         m_per = m_per - 1;
      end
   endtask

   task automatic track_eval(input int th);
      m_locked = (th <= 8);
      if (th > m_prev) m_dir = -m_dir;
      m_loss = m_locked ? 0 : m_loss + 1;
      m_prev = th;
      if (m_loss == 16) begin
         m_mode     = M_SWEEP;
         m_per      = 175;
         m_locked   = 0;
         m_best     = 255;
         m_best_per = 175;
         m_loss     = 0;
      end else if (m_per + m_dir > 175 || m_per + m_dir < 140) begin
         m_dir = -m_dir;
      end else begin
         m_per = m_per + m_dir;
      end
   endtask

   task automatic model_clk(input logic r, input logic en, input logic tv, input int th);
      if (!r) begin
         m_mode = M_IDLE; m_per = 175; m_best = 255; m_best_per = 175;
         m_prev = 0; m_dir = -1; m_cnt = 0; m_loss = 0; m_locked = 0;
      end else if (!en) begin
         m_mode = M_IDLE; m_per = 175; m_best_per = 175;
         m_dir = -1; m_cnt = 0; m_loss = 0; m_locked = 0;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_SWEEP; m_best = 255; m_best_per = 175; m_cnt = 0; m_loss = 0;
      end else if ((m_mode == M_SWEEP || m_mode == M_TRACK) && tv) begin
         m_cnt++;
         if (m_cnt == 4) begin
            m_cnt = 0;
            if (m_mode == M_SWEEP) sweep_eval(th);
            else                   track_eval(th);
         end
      end
   endtask

   task automatic compare_all();
      chk("period",     int'(bus.period),     m_per);
      chk("best_theta", int'(bus.best_theta), m_best);
      chk("sweep_busy", int'(bus.sweep_busy), int'(m_mode == M_SWEEP));
      chk("locked",     int'(bus.locked),     m_locked);
      chk("fault",      int'(bus.fault),      int'(m_mode == M_FAULT));
   endtask

   task automatic step(input logic r, input logic en, input logic tv, input int th, input logic do_chk);
      @(negedge clk5MHz);
      rst_n           = r;
      bus.enable      = en;
      bus.theta_valid = tv;
      bus.abs_theta   = th[7:0];
      @(posedge clk5MHz);
      model_clk(r, en, tv, th);
      #1;
      if (do_chk) compare_all();
   endtask

   task automatic valid_pulse();
      int g;
      g = $urandom_range(1, 6);
      for (int k = 0; k < g; k++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b1, theta_for(m_per), 1'b1);
   endtask

   task automatic run_evals(input int n);
      for (int k = 0; k < 4 * n; k++) valid_pulse();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int held;
      int r;
      bus.enable      = 1'b1;
      bus.theta_valid = 1'b0;
      bus.abs_theta   = '0;

      // Reset with enable already high
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
      chk("rst_period",     int'(bus.period), 175);
      chk("rst_locked",     int'(bus.locked), 0);
      chk("rst_fault",      int'(bus.fault), 0);
      chk("rst_sweep_busy", int'(bus.sweep_busy), 0);
      chk("rst_best_theta", int'(bus.best_theta), 255);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      chk("start_busy", int'(bus.sweep_busy), 1);

      // Full sweep with resonance at 158
      pres = 158;
      for (int i = 0; i < 200 && m_mode == M_SWEEP; i++) begin
         valid_pulse();
         if (i == 2) chk("sweep_hold", int'(bus.period), 175);
         if (i == 3) chk("sweep_step", int'(bus.period), 174);
      end
      chk("lock_period", int'(bus.period), 158);
      chk("lock_best",   int'(bus.best_theta), 0);
      chk("lock_busy",   int'(bus.sweep_busy), 0);
      chk("lock_locked_pre", int'(bus.locked), 0);
      run_evals(1);
      chk("lock_locked", int'(bus.locked), 1);

      // Drift 158 -> 161
      run_evals(8);
      pres = 161;
      run_evals(12);
      chk("drift_band",   int'(bus.period >= 160 && bus.period <= 162), 1);
      chk("drift_locked", int'(bus.locked), 1);

      // Loss of lock
      force_th = 200;
      run_evals(15);
      chk("loss_15_busy", int'(bus.sweep_busy), 0);
      run_evals(1);
      chk("loss_busy",   int'(bus.sweep_busy), 1);
      chk("loss_period", int'(bus.period), 175);
      chk("loss_locked", int'(bus.locked), 0);
      force_th = -1;
      for (int i = 0; i < 200 && m_mode == M_SWEEP; i++) valid_pulse();
      chk("relock_period", int'(bus.period), 161);

      // Reset while tracking
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      chk("mid_rst_period", int'(bus.period), 175);
      chk("mid_rst_best",   int'(bus.best_theta), 255);
      chk("mid_rst_locked", int'(bus.locked), 0);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);

      // Abort at period 160 coincident with theta_valid
      pres = 158;
      for (int i = 0; i < 120 && m_per != 160; i++) valid_pulse();
      step(1'b1, 1'b1, 1'b0, 0, 1'b0);
      held = m_best;
      step(1'b1, 1'b0, 1'b1, theta_for(m_per), 1'b1);
      chk("abort_period", int'(bus.period), 175);
      chk("abort_busy",   int'(bus.sweep_busy), 0);
      chk("abort_best",   int'(bus.best_theta), held);

      // No resonance: constant theta 60
      force_th = 60;
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      for (int i = 0; i < 200 && m_mode == M_SWEEP; i++) valid_pulse();
      chk("fault_flag",   int'(bus.fault), 1);
      chk("fault_period", int'(bus.period), 175);
      chk("fault_best",   int'(bus.best_theta), 60);
      run_evals(2);
      chk("fault_sticky", int'(bus.fault), 1);
      step(1'b1, 1'b0, 1'b0, 0, 1'b1);
      chk("fault_clear",  int'(bus.fault), 0);
      force_th = -1;

      // Random traffic: drifting resonance, noisy theta, enable drops, resets
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 30) == 0) pres = $urandom_range(140, 175);
         force_th = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1;
         if (r < 2) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b1);
         end else if (r < 7) begin
            step(1'b1, 1'b0, 1'(r[0]), theta_for(m_per), 1'b1);
            step(1'b1, 1'b0, 1'b0, 0, 1'b1);
         end else begin
            valid_pulse();
         end
      end
      force_th = -1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
